// File: rtl/hamm_exec_unit.sv
// hamm_exec_unit: multi-cycle HAMM execution unit, result = popcount(a ^ b),
// counted STEP bits per cycle. Optional macro HAMM_EARLY_EXIT_EN ends the
// count as soon as the remaining operand bits are all zero.
// Ports: clock, reset (sync, active-high), en, aluc, a, b (operands in);
//        result (registered distance), busy (COUNT), done (1-cycle pulse),
//        stall (combinational hold for PC / register write) out.
module hamm_exec_unit #(
   parameter int          WIDTH   = 32,
   parameter int          STEP    = 4,
   parameter logic [3:0]  HAMM_OP = 4'b1011
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       aluc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [31:0]      result,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int NCH = WIDTH / STEP;
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [31:0]      result_q, result_d;

   logic             go;
   logic             stall_raw;
   logic [WIDTH-1:0] x_shift;
   logic [CW-1:0]    pc;
   logic [CW-1:0]    cnt_sum;
   logic             last;

   always_comb begin
      go        = en && (aluc == HAMM_OP);
      state_d   = state_q;
      x_d       = x_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      result_d  = result_q;
      stall_raw = 1'b0;

      x_shift = x_q >> STEP;
      pc      = '0;
      for (int i = 0; i < STEP; i++) begin
         pc = pc + CW'(x_q[i]);
      end
      cnt_sum = cnt_q + pc;

      last = (idx_q == LAST);
`ifdef HAMM_EARLY_EXIT_EN
      // nothing left to count once the shifted remainder is empty
      last = last || (x_shift == '0);
`endif

      case (state_q)
         S_IDLE: begin
            stall_raw = go;
            if (go) begin
               x_d     = a ^ b;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            stall_raw = 1'b1;
            if (!go) begin
               // instruction squashed: drop the work, keep old result
               state_d = S_IDLE;
            end else begin
               x_d   = x_shift;
               cnt_d = cnt_sum;
               idx_d = idx_q + 1'b1;
               if (last) begin
                  result_d = 32'(cnt_sum);
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            // retire cycle: go is ignored here on purpose
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;
   assign busy   = (state_q == S_COUNT);
   assign done   = (state_q == S_DONE);
   assign stall  = !reset && stall_raw;

endmodule

// File: tb/tb_hamm_exec_unit.sv
// tb_hamm_exec_unit: directed test of hamm_exec_unit against a cycle-level
// reference model of the HAMM instruction timing and result.
module tb_hamm_exec_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        en    = 1'b0;
   logic [3:0]  aluc  = 4'b0000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] result;
   logic        busy;
   logic        done;
   logic        stall;

   int checks   = 0;
   int failures = 0;

`ifdef HAMM_EARLY_EXIT_EN
   localparam int EARLY = 1;
`else
   localparam int EARLY = 0;
`endif

   hamm_exec_unit dut (
      .clock  (clock),
      .reset  (reset),
      .en     (en),
      .aluc   (aluc),
      .a      (a),
      .b      (b),
      .result (result),
      .busy   (busy),
      .done   (done),
      .stall  (stall)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // number of COUNT cycles the unit needs for difference word x
   function automatic int lat(input logic [31:0] x);
      int h;
      h = 7;
      if (EARLY != 0) begin
         h = 0;
         for (int k = 0; k < 8; k++)
            if (((x >> (4 * k)) & 32'hF) != 0) h = k;
      end
      return h + 1;
   endfunction

   // reference model: count-down of remaining COUNT cycles
   int   m_left = 0;
   int   m_res  = 0;
   int   m_tgt  = 0;
   logic m_done = 1'b0;
   logic m_go;
   assign m_go = en && (aluc == 4'b1011);

   always @(posedge clock) begin
      if (reset) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         if (!m_go) begin
            m_left <= 0;
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_done <= 1'b1;
               m_res  <= m_tgt;
            end
         end
      end else if (m_go) begin
         m_tgt  <= $countones(a ^ b);
         m_left <= lat(a ^ b);
      end
   end

   always @(negedge clock) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("stall", 32'(stall),
          32'(!reset && (m_left > 0 || (!m_done && m_go))));
      chk("result", result, 32'(m_res));
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // issue one HAMM, hold it until done, report timing seen
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                         output int dcyc, output int nstall,
                         output int nbusy, output logic [31:0] rd);
      en     = 1'b1;
      aluc   = 4'b1011;
      a      = ta;
      b      = tb_;
      dcyc   = -1;
      nstall = 0;
      nbusy  = 0;
      rd     = '0;
      for (int c = 0; c < 40; c++) begin
         #3;
         if (stall) nstall++;
         if (busy) nbusy++;
         if (done) begin
            dcyc = c;
            rd   = result;
         end
         cyc();
         if (c == 0) a = ta ^ 32'h5A5A_0F0F;
         if (dcyc >= 0) break;
      end
      en = 1'b0;
      if (dcyc < 0) begin
         checks++;
         failures++;
         $display("FAIL op_timeout: no done within 40 cycles");
      end
   endtask

   initial begin
      int dc, ns, nb, cnt_s, cnt_d;
      logic [31:0] rd;

      repeat (3) cyc();
      reset = 1'b0;
      #3;
      chk("rst_result", result, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      cyc();

      run_op(32'hFFFF_FFFF, 32'h0, dc, ns, nb, rd);
      chk("t1_done_cyc", dc, 32'd9);
      chk("t1_stall_n", ns, 32'd9);
      chk("t1_busy_n", nb, 32'd8);
      chk("t1_result", rd, 32'd32);
      cyc();
      cyc();

      run_op(32'hA5A5_A5A5, 32'hA5A5_A5A4, dc, ns, nb, rd);
      chk("t2_result", rd, 32'd1);
      chk("t2_done_cyc", dc, (EARLY != 0) ? 32'd2 : 32'd9);
      chk("t2_stall_n", ns, (EARLY != 0) ? 32'd2 : 32'd9);
      cyc();
      cyc();

      run_op(32'h0000_000F, 32'h0, dc, ns, nb, rd);
      chk("b2b1_result", rd, 32'd4);
      chk("b2b1_done_cyc", dc, (EARLY != 0) ? 32'd2 : 32'd9);
      run_op(32'h1234_5678, 32'h8765_4321, dc, ns, nb, rd);
      chk("b2b2_result", rd, 32'd14);
      chk("b2b2_done_cyc", dc, 32'd9);
      cyc();
      cyc();

      en    = 1'b1;
      aluc  = 4'b0000;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0;
      cnt_s = 0;
      cnt_d = 0;
      for (int i = 0; i < 5; i++) begin
         #3;
         if (stall || busy) cnt_s++;
         if (done) cnt_d++;
         cyc();
      end
      chk("add_stall_n", cnt_s, 32'd0);
      chk("add_done_n", cnt_d, 32'd0);
      chk("add_result", result, 32'd14);
      en = 1'b0;
      cyc();

      en   = 1'b1;
      aluc = 4'b1011;
      a    = 32'hFFFF_FFFF;
      b    = 32'h0;
      repeat (3) cyc();
      en    = 1'b0;
      cnt_d = 0;
      for (int i = 0; i < 6; i++) begin
         #3;
         if (done) cnt_d++;
         cyc();
      end
      chk("abort_done_n", cnt_d, 32'd0);
      chk("abort_result", result, 32'd14);
      chk("abort_busy", 32'(busy), 32'd0);

      en = 1'b1;
      repeat (4) cyc();
      reset = 1'b1;
      #3;
      chk("rstmid_stall", 32'(stall), 32'd0);
      cyc();
      reset = 1'b0;
      en    = 1'b0;
      #3;
      chk("rstmid_result", result, 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      cyc();

      run_op(32'h0000_00FF, 32'h0000_000F, dc, ns, nb, rd);
      chk("post_rst_result", rd, 32'd4);
      chk("post_rst_done_cyc", dc, (EARLY != 0) ? 32'd3 : 32'd9);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
